// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame loader: FSM state encoding and
// bit-counter width helper.
package serial_frame_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    DATA,
    FLAG,
    PAR,
    LOAD
  } state_t;

  // Counter must reach SIZE, so it needs one more code than SIZE-1
  function automatic int cntWidth(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Data-bit counter for the serial frame loader. Cleared at frame start,
// incremented per accepted data bit, saturates at SIZE.
module frame_bit_counter
  import serial_frame_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int CNT_W = cntWidth(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  // Clear has priority; increment stops at SIZE so the count never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(SIZE))) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(SIZE - 1));

endmodule

// File: rtl/serial_frame_loader.sv
// Serial frame loader: deserialises SIZE data bits (LSB first) plus a flag
// bit per start request and presents them with a one-cycle ld strobe.
// Optional feature: define PARITY_CHECK_EN to add a trailing even-parity bit
// over {flag, data}; a mismatch pulses err and suppresses the load.
module serial_frame_loader
  import serial_frame_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int CNT_W = cntWidth(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            serIn,
  input  logic            serValid,
  output logic            busy,
  output logic            ld,
  output logic [SIZE-1:0] dataOut,
  output logic            flagOut,
  output logic            err
);

  state_t            state;
  logic [SIZE-1:0]   shiftReg;
  logic [CNT_W-1:0]  bitCnt;
  logic              bitLast;
  logic              cntClr;
  logic              cntInc;
`ifdef PARITY_CHECK_EN
  logic              flagReg;
`endif

  assign cntClr = (state == IDLE) && start;
  assign cntInc = (state == DATA) && serValid;

  frame_bit_counter #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cntClr),
    .inc      (cntInc),
    .count    (bitCnt),
    .terminal (bitLast)
  );

  // Frame FSM, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shiftReg <= '0;
      busy     <= 1'b0;
      ld       <= 1'b0;
      err      <= 1'b0;
      dataOut  <= '0;
      flagOut  <= 1'b0;
`ifdef PARITY_CHECK_EN
      flagReg  <= 1'b0;
`endif
    end else begin
      ld  <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= DATA;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          if (serValid) begin
            for (int i = 0; i < SIZE; i++) begin
              if (bitCnt == CNT_W'(i)) shiftReg[i] <= serIn;
            end
            if (bitLast) state <= FLAG;
          end
        end
        FLAG: begin
          if (serValid) begin
`ifdef PARITY_CHECK_EN
            flagReg <= serIn;
            state   <= PAR;
`else
            // Outputs and ld rise together so downstream sees a whole frame
            state   <= LOAD;
            ld      <= 1'b1;
            dataOut <= shiftReg;
            flagOut <= serIn;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PAR: begin
          if (serValid) begin
            if (serIn == ^{flagReg, shiftReg}) begin
              state   <= LOAD;
              ld      <= 1'b1;
              dataOut <= shiftReg;
              flagOut <= flagReg;
            end else begin
              // Bad frame: report and drop, previous outputs stay visible
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
`endif
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed bench for serial_frame_loader: a SIZE=2 instance for the main
// scenarios and a SIZE=4 instance for the back-to-back frame case.
module tb_serial_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, serIn = 1'b0, serValid = 1'b0;
  logic       busy, ld, flagOut, err;
  logic [1:0] dataOut;
  logic       start4 = 1'b0, ser4 = 1'b0, val4 = 1'b0;
  logic       busy4, ld4, flagOut4, err4;
  logic [3:0] dataOut4;

  int checks = 0;
  int passes = 0;
  int ldCount = 0;
  int busyCount = 0;

  serial_frame_loader #(.SIZE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .serIn(serIn), .serValid(serValid),
    .busy(busy), .ld(ld), .dataOut(dataOut), .flagOut(flagOut), .err(err)
  );

  serial_frame_loader #(.SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .serIn(ser4), .serValid(val4),
    .busy(busy4), .ld(ld4), .dataOut(dataOut4), .flagOut(flagOut4), .err(err4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld) ldCount++;
    if (busy) busyCount++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit2(input logic b);
    serValid = 1'b1;
    serIn    = b;
    tick();
    serValid = 1'b0;
  endtask

  // Flag bit, followed by the parity bit when that feature is built in
  task automatic sendFlag(input logic f, input logic p);
    bit2(f);
`ifdef PARITY_CHECK_EN
    bit2(p);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (ld !== 1'b0) $display("FAIL reset_ld: got %b want 0", ld); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    checks++; if (dataOut !== 2'b00) $display("FAIL reset_data: got %b want 00", dataOut); else passes++;
    checks++; if (flagOut !== 1'b0) $display("FAIL reset_flag: got %b want 0", flagOut); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int ld0, busy0;
    ld0 = ldCount;
    busy0 = busyCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", busy); else passes++;
    bit2(1'b1);
    bit2(1'b0);
    sendFlag(1'b1, 1'b0);
    checks++; if (ld !== 1'b1) $display("FAIL basic_ld: got %b want 1", ld); else passes++;
    checks++; if (dataOut !== 2'b01) $display("FAIL basic_data: got %b want 01", dataOut); else passes++;
    checks++; if (flagOut !== 1'b1) $display("FAIL basic_flag: got %b want 1", flagOut); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else passes++;
    tick();
    checks++; if (ld !== 1'b0) $display("FAIL basic_ld_drop: got %b want 0", ld); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else passes++;
    checks++; if (ldCount - ld0 !== 1) $display("FAIL basic_ld_count: got %0d want 1", ldCount - ld0); else passes++;
`ifdef PARITY_CHECK_EN
    checks++; if (busyCount - busy0 !== 5) $display("FAIL basic_busy_cycles: got %0d want 5", busyCount - busy0); else passes++;
`else
    checks++; if (busyCount - busy0 !== 4) $display("FAIL basic_busy_cycles: got %0d want 4", busyCount - busy0); else passes++;
`endif
  endtask

  task automatic test_gaps();
    int ld0;
    ld0 = ldCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit2(1'b1);
    tick();
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL gaps_busy_stall: got %b want 1", busy); else passes++;
    bit2(1'b1);
    tick();
    checks++; if (ld !== 1'b0) $display("FAIL gaps_ld_early: got %b want 0", ld); else passes++;
    sendFlag(1'b0, 1'b0);
    checks++; if (ld !== 1'b1) $display("FAIL gaps_ld: got %b want 1", ld); else passes++;
    checks++; if (dataOut !== 2'b11) $display("FAIL gaps_data: got %b want 11", dataOut); else passes++;
    checks++; if (flagOut !== 1'b0) $display("FAIL gaps_flag: got %b want 0", flagOut); else passes++;
    tick();
    checks++; if (ldCount - ld0 !== 1) $display("FAIL gaps_ld_count: got %0d want 1", ldCount - ld0); else passes++;
  endtask

  task automatic test_ignored_inputs();
    int ld0;
    ld0 = ldCount;
    serValid = 1'b1;
    serIn = 1'b1;
    tick();
    tick();
    tick();
    serValid = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL idle_valid_busy: got %b want 0", busy); else passes++;
    checks++; if (dataOut !== 2'b11) $display("FAIL idle_valid_data: got %b want 11", dataOut); else passes++;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit2(1'b0);
    start = 1'b1;
    bit2(1'b1);
    start = 1'b0;
    sendFlag(1'b1, 1'b0);
    checks++; if (dataOut !== 2'b10) $display("FAIL midstart_data: got %b want 10", dataOut); else passes++;
    checks++; if (flagOut !== 1'b1) $display("FAIL midstart_flag: got %b want 1", flagOut); else passes++;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL midstart_busy: got %b want 0", busy); else passes++;
    checks++; if (ldCount - ld0 !== 1) $display("FAIL midstart_ld_count: got %0d want 1", ldCount - ld0); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int ld0;
    ld0 = ldCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit2(1'b1);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
    checks++; if (dataOut !== 2'b00) $display("FAIL midrst_data: got %b want 00", dataOut); else passes++;
    checks++; if (flagOut !== 1'b0) $display("FAIL midrst_flag: got %b want 0", flagOut); else passes++;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (ldCount - ld0 !== 0) $display("FAIL midrst_no_ld: got %0d want 0", ldCount - ld0); else passes++;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit2(1'b0);
    bit2(1'b1);
    sendFlag(1'b1, 1'b0);
    checks++; if (ld !== 1'b1) $display("FAIL postrst_ld: got %b want 1", ld); else passes++;
    checks++; if (dataOut !== 2'b10) $display("FAIL postrst_data: got %b want 10", dataOut); else passes++;
    checks++; if (flagOut !== 1'b1) $display("FAIL postrst_flag: got %b want 1", flagOut); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] second;
    int gap;
    int expGap;
    // Bits after the first ld: LOAD slot, IDLE slot, data 1,0,1,1, flag 1, parity 0
    second = 9'b0_0_1_1_1_0_1_0_0;
`ifdef PARITY_CHECK_EN
    expGap = 8;
`else
    expGap = 7;
`endif
    start4 = 1'b1;
    val4 = 1'b1;
    tick();
    ser4 = 1'b0; tick();
    ser4 = 1'b1; tick();
    ser4 = 1'b0; tick();
    ser4 = 1'b0; tick();
    ser4 = 1'b0; tick();
`ifdef PARITY_CHECK_EN
    ser4 = 1'b1; tick();
`endif
    checks++; if (ld4 !== 1'b1) $display("FAIL b2b_ld1: got %b want 1", ld4); else passes++;
    checks++; if (dataOut4 !== 4'b0010) $display("FAIL b2b_data1: got %b want 0010", dataOut4); else passes++;
    checks++; if (flagOut4 !== 1'b0) $display("FAIL b2b_flag1: got %b want 0", flagOut4); else passes++;
    gap = 0;
    for (int k = 1; k <= 12; k++) begin
      ser4 = (k <= 9) ? second[k-1] : 1'b0;
      tick();
      if (k == 1) begin
        checks++; if (ld4 !== 1'b0) $display("FAIL b2b_ld_width: got %b want 0", ld4); else passes++;
      end
      if (ld4 === 1'b1 && gap == 0) gap = k;
    end
    start4 = 1'b0;
    val4 = 1'b0;
    checks++; if (gap !== expGap) $display("FAIL b2b_period: got %0d want %0d", gap, expGap); else passes++;
    checks++; if (dataOut4 !== 4'b1101) $display("FAIL b2b_data2: got %b want 1101", dataOut4); else passes++;
    checks++; if (flagOut4 !== 1'b1) $display("FAIL b2b_flag2: got %b want 1", flagOut4); else passes++;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int ld0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit2(1'b1);
    bit2(1'b0);
    sendFlag(1'b1, 1'b0);
    checks++; if (ld !== 1'b1) $display("FAIL par_ok_ld: got %b want 1", ld); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL par_ok_err: got %b want 0", err); else passes++;
    checks++; if (dataOut !== 2'b01) $display("FAIL par_ok_data: got %b want 01", dataOut); else passes++;
    tick();
    ld0 = ldCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit2(1'b1);
    bit2(1'b1);
    sendFlag(1'b0, 1'b1);
    checks++; if (err !== 1'b1) $display("FAIL par_bad_err: got %b want 1", err); else passes++;
    checks++; if (ld !== 1'b0) $display("FAIL par_bad_ld: got %b want 0", ld); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL par_bad_busy: got %b want 0", busy); else passes++;
    checks++; if (dataOut !== 2'b01) $display("FAIL par_bad_data: got %b want 01", dataOut); else passes++;
    checks++; if (flagOut !== 1'b1) $display("FAIL par_bad_flag: got %b want 1", flagOut); else passes++;
    tick();
    checks++; if (err !== 1'b0) $display("FAIL par_err_width: got %b want 0", err); else passes++;
    checks++; if (ldCount - ld0 !== 0) $display("FAIL par_bad_no_ld: got %0d want 0", ldCount - ld0); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_ignored_inputs();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
